snake_body_ctrl: RTL and testbench

- Game-side counterpart of the apple/eat logic: owns the snake, produces head_x/head_y and the game mode, and consumes the eat_ pulse to grow the body.
- Holds the segment list, paces movement with a tick divider, applies direction keys, and detects wall and self collisions.
- Answers per-cell body queries from the VGA renderer.

---
 rtl/snake_body_ctrl.sv | 142 ++++++++++++++
 tb/tb_snake_body_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_ctrl.sv
// Snake body controller: owns the segment list, paces moves with a tick divider,
// applies steering and growth, detects wall/self collisions and answers cell queries.
module snake_body_ctrl #(
  parameter int TICK_DIV = 12500000,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int X_MAX    = 38,
  parameter int Y_MAX    = 28
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_start,
  input  logic       eat_,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [1:0] mode,
  output logic [4:0] snake_len,
  input  logic [5:0] query_x,
  input  logic [5:0] query_y,
  output logic       is_body,
  output logic       is_head
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {M_READY = 2'd0, M_PLAY = 2'd1, M_DEAD = 2'd2} mode_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  mode_t          state;
  dir_t           dir, pending_dir, key_dir;
  logic [5:0]     seg_x [MAX_LEN];
  logic [5:0]     seg_y [MAX_LEN];
  logic [CW-1:0]  cnt;
  logic           grow_pending, key_start_q;
  logic           start_edge, do_init, tick, grow;
  logic           wall_hit, self_hit, body_hit;
  logic [5:0]     next_x, next_y;

  assign head_x     = seg_x[0];
  assign head_y     = seg_y[0];
  assign mode       = state;
  assign start_edge = key_start & ~key_start_q;
  assign do_init    = rst | ((state == M_DEAD) & start_edge);
  assign tick       = (state == M_PLAY) && (cnt == CW'(TICK_DIV - 1));
  assign grow       = grow_pending | eat_;

  // Reverse keys are skipped so the next key in priority order can still win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    key_dir = pending_dir;
    if (key_up && dir != D_DOWN)           key_dir = D_UP;
    else if (key_down && dir != D_UP)      key_dir = D_DOWN;
    else if (key_left && dir != D_RIGHT)   key_dir = D_LEFT;
    else if (key_right && dir != D_LEFT)   key_dir = D_RIGHT;
  end

  always_comb begin
    next_x = seg_x[0];
    next_y = seg_y[0];
    unique case (pending_dir)
      D_UP:    next_y = seg_y[0] - 6'd1;
      D_DOWN:  next_y = seg_y[0] + 6'd1;
      D_LEFT:  next_x = seg_x[0] - 6'd1;
      default: next_x = seg_x[0] + 6'd1;
    endcase
  end

  assign wall_hit = (next_x == 6'd0) || (next_x > 6'(X_MAX)) ||
                    (next_y == 6'd0) || (next_y > 6'(Y_MAX));

  // The tail cell only blocks the head when the snake is about to grow.
  always_comb begin
    self_hit = 1'b0;
    body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (seg_x[i] == next_x && seg_y[i] == next_y &&
          (i < int'(snake_len) - 1 || (i == int'(snake_len) - 1 && grow)))
        self_hit = 1'b1;
      if (i < int'(snake_len) && seg_x[i] == query_x && seg_y[i] == query_y)
        body_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (do_init) begin
      state        <= M_READY;
      snake_len    <= 5'(INIT_LEN);
      dir          <= D_RIGHT;
      pending_dir  <= D_RIGHT;
      grow_pending <= 1'b0;
      cnt          <= '0;
      is_body      <= 1'b0;
      is_head      <= 1'b0;
      key_start_q  <= rst ? 1'b0 : key_start;
      // NOTE: the segment array is flops, not RAM, so restart can reload it in one edge.
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(10 - i);
        seg_y[i] <= 6'd15;
      end
    end else begin
      key_start_q <= key_start;
      is_body     <= body_hit;
      is_head     <= (seg_x[0] == query_x) && (seg_y[0] == query_y);
      unique case (state)
        M_READY: begin
          if (start_edge) begin
            state <= M_PLAY;
            cnt   <= '0;
          end
        end
        M_PLAY: begin
          cnt         <= tick ? '0 : cnt + CW'(1);
          pending_dir <= key_dir;
          if (tick) begin
            if (wall_hit || self_hit) begin
              state <= M_DEAD;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0]     <= next_x;
              seg_y[0]     <= next_y;
              dir          <= pending_dir;
              grow_pending <= 1'b0;
              if (grow && snake_len < 5'(MAX_LEN))
                snake_len <= snake_len + 5'd1;
            end
          end else if (eat_) begin
            grow_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl with TICK_DIV=4: per-cycle vector table for
// start/movement/steering, then hand sequences for growth, walls, self-hit and restart.
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       key_start = 1'b0, eat_ = 1'b0;
  logic [5:0] query_x = '0, query_y = '0;
  logic [5:0] head_x, head_y;
  logic [1:0] mode;
  logic [4:0] snake_len;
  logic       is_body, is_head;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_body_ctrl #(.TICK_DIV(4)) dut (
    .clk_50MHz(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_start(key_start), .eat_(eat_),
    .head_x(head_x), .head_y(head_y), .mode(mode), .snake_len(snake_len),
    .query_x(query_x), .query_y(query_y), .is_body(is_body), .is_head(is_head)
  );

  typedef struct {
    logic       rst, start, up, down, left, right, eat;
    logic [5:0] qx, qy;
    logic [5:0] hx, hy;
    logic [1:0] md;
    logic [4:0] len;
    logic       body, head;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(input logic r, s, u, d, l, rt, e,
                              input int qx, qy, hx, hy, md, len,
                              input logic body, head);
    vec_t v;
    v.rst = r; v.start = s; v.up = u; v.down = d; v.left = l; v.right = rt; v.eat = e;
    v.qx = 6'(qx); v.qy = 6'(qy); v.hx = 6'(hx); v.hy = 6'(hy);
    v.md = 2'(md); v.len = 5'(len); v.body = body; v.head = head;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic keys(input logic u, d, l, r);
    key_up = u; key_down = d; key_left = l; key_right = r;
  endtask

  // Press during the first cycle of a tick window, then finish the window.
  task automatic step_dir(input logic u, d, l, r);
    keys(u, d, l, r);
    cyc(1);
    keys(0, 0, 0, 0);
    cyc(3);
  endtask

  task automatic eat_move();
    eat_ = 1'b1;
    cyc(1);
    eat_ = 1'b0;
    cyc(3);
  endtask

  task automatic restart_play();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
  endtask

  task automatic check_state(input string name, input int hx, hy, md, len);
    check({name, "_hx"}, int'(head_x), hx);
    check({name, "_hy"}, int'(head_y), hy);
    check({name, "_mode"}, int'(mode), md);
    check({name, "_len"}, int'(snake_len), len);
  endtask

  initial begin
    //            rst st u d l r e  qx qy  hx hy md len body head
    vecs[0]  = mk(1, 0, 0,0,0,0, 0, 10,15, 10,15, 0, 3, 0, 0);
    vecs[1]  = mk(0, 0, 0,0,0,0, 0, 10,15, 10,15, 0, 3, 1, 1);
    vecs[2]  = mk(0, 1, 0,0,0,0, 0,  9,15, 10,15, 1, 3, 1, 0);
    vecs[3]  = mk(0, 1, 0,0,0,0, 0,  8,15, 10,15, 1, 3, 1, 0);
    vecs[4]  = mk(0, 0, 0,0,0,0, 0,  7,15, 10,15, 1, 3, 0, 0);
    vecs[5]  = mk(0, 0, 0,0,0,0, 0, 11,15, 10,15, 1, 3, 0, 0);
    vecs[6]  = mk(0, 0, 0,0,0,0, 0, 11,15, 11,15, 1, 3, 0, 0);
    vecs[7]  = mk(0, 0, 0,0,0,0, 0,  8,15, 11,15, 1, 3, 0, 0);
    vecs[8]  = mk(0, 0, 0,0,0,0, 0, 11,15, 11,15, 1, 3, 1, 1);
    vecs[9]  = mk(0, 0, 0,0,0,0, 0,  0, 0, 11,15, 1, 3, 0, 0);
    vecs[10] = mk(0, 0, 0,0,0,0, 0,  0, 0, 12,15, 1, 3, 0, 0);
    vecs[11] = mk(0, 0, 0,0,1,0, 0, 12,15, 12,15, 1, 3, 1, 1);
    vecs[12] = mk(0, 0, 0,0,0,0, 0,  0, 0, 12,15, 1, 3, 0, 0);
    vecs[13] = mk(0, 0, 0,0,0,0, 0,  0, 0, 12,15, 1, 3, 0, 0);
    vecs[14] = mk(0, 0, 0,0,0,0, 0,  0, 0, 13,15, 1, 3, 0, 0);
    vecs[15] = mk(0, 0, 0,0,1,0, 0,  0, 0, 13,15, 1, 3, 0, 0);
    vecs[16] = mk(0, 0, 1,0,0,0, 0,  0, 0, 13,15, 1, 3, 0, 0);
    vecs[17] = mk(0, 0, 0,0,0,0, 0,  0, 0, 13,15, 1, 3, 0, 0);
    vecs[18] = mk(0, 0, 0,0,0,0, 0,  0, 0, 13,14, 1, 3, 0, 0);
    vecs[19] = mk(0, 0, 0,0,1,1, 0,  0, 0, 13,14, 1, 3, 0, 0);
    vecs[20] = mk(0, 0, 0,0,0,0, 0,  0, 0, 13,14, 1, 3, 0, 0);
    vecs[21] = mk(0, 0, 0,0,0,0, 0,  0, 0, 13,14, 1, 3, 0, 0);
    vecs[22] = mk(0, 0, 0,0,0,0, 0,  0, 0, 12,14, 1, 3, 0, 0);
    vecs[23] = mk(0, 0, 1,1,0,0, 0,  0, 0, 12,14, 1, 3, 0, 0);
    vecs[24] = mk(0, 0, 0,0,0,0, 0,  0, 0, 12,14, 1, 3, 0, 0);
    vecs[25] = mk(0, 0, 0,0,0,0, 0,  0, 0, 12,14, 1, 3, 0, 0);
    vecs[26] = mk(0, 0, 0,0,0,0, 0, 13,14, 12,13, 1, 3, 1, 0);

    for (int i = 0; i < 27; i++) begin
      rst = vecs[i].rst; key_start = vecs[i].start; eat_ = vecs[i].eat;
      keys(vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right);
      query_x = vecs[i].qx; query_y = vecs[i].qy;
      cyc(1);
      check_state($sformatf("vec%0d", i), vecs[i].hx, vecs[i].hy, vecs[i].md, vecs[i].len);
      check($sformatf("vec%0d_body", i), int'(is_body), int'(vecs[i].body));
      check($sformatf("vec%0d_head", i), int'(is_head), int'(vecs[i].head));
    end
    rst = 1'b0; key_start = 1'b0; eat_ = 1'b0; keys(0, 0, 0, 0);

    // Growth: eat two cycles before a tick, then eat on the tick cycle itself.
    restart_play();
    cyc(1);
    eat_ = 1'b1; cyc(1); eat_ = 1'b0;
    cyc(2);
    check_state("grow1", 11, 15, 1, 4);
    query_x = 6'd8; query_y = 6'd15;
    cyc(1);
    check("grow1_old_tail_body", int'(is_body), 1);
    cyc(3);
    check_state("grow1_cleared", 12, 15, 1, 4);
    cyc(3);
    eat_ = 1'b1; cyc(1); eat_ = 1'b0;
    check_state("grow_on_tick", 13, 15, 1, 5);
    for (int k = 0; k < 11; k++) eat_move();
    check_state("grow_max", 24, 15, 1, 16);
    eat_move();
    check_state("grow_discard", 25, 15, 1, 16);
    query_x = 6'd9; query_y = 6'd15;
    cyc(1);
    check("max_vacated_tail", int'(is_body), 0);
    query_x = 6'd10;
    cyc(1);
    check("max_last_seg", int'(is_body), 1);

    // Wall at the top edge, frozen DEAD state, restart and re-entry to PLAY.
    restart_play();
    step_dir(1, 0, 0, 0);
    check_state("up_first", 10, 14, 1, 3);
    repeat (13) cyc(4);
    check_state("at_top", 10, 1, 1, 3);
    cyc(4);
    check_state("wall_dead", 10, 1, 2, 3);
    eat_ = 1'b1; cyc(1); eat_ = 1'b0;
    cyc(7);
    check_state("dead_frozen", 10, 1, 2, 3);
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    check_state("restart", 10, 15, 0, 3);
    cyc(5);
    check_state("ready_idle", 10, 15, 0, 3);
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    check("replay_mode", int'(mode), 1);
    cyc(4);
    check_state("replay_move", 11, 15, 1, 3);

    // Length 5 turning into its own body.
    restart_play();
    eat_move();
    eat_move();
    check_state("len5", 12, 15, 1, 5);
    step_dir(0, 1, 0, 0);
    step_dir(0, 0, 1, 0);
    check_state("len5_turned", 11, 16, 1, 5);
    step_dir(1, 0, 0, 0);
    check_state("self_dead", 11, 16, 2, 5);
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    check_state("self_restart", 10, 15, 0, 3);

    // Length 4 chasing its tail survives; then reset mid-PLAY.
    restart_play();
    eat_move();
    step_dir(0, 1, 0, 0);
    step_dir(0, 0, 1, 0);
    step_dir(1, 0, 0, 0);
    check_state("chase_up", 10, 15, 1, 4);
    step_dir(0, 0, 0, 1);
    check_state("chase_right", 11, 15, 1, 4);
    query_x = 6'd11; query_y = 6'd15;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_state("mid_reset", 10, 15, 0, 3);
    check("mid_reset_body", int'(is_body), 0);
    check("mid_reset_head", int'(is_head), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
